// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage
package fetch_pkg;
    typedef enum logic [1:0] {RUN, DRAIN, HALT} fetch_state_t;
    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;
    localparam int DEFAULT_XLEN = 32;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with occupancy count and synchronous flush
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic [WIDTH-1:0]       i_wdata,
    output logic [WIDTH-1:0]       o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;
    assign o_count = r_count;
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_rdata = r_mem[r_rd_ptr];
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    // pointer and occupancy update; flush empties the queue regardless of push/pop
    always_ff @(posedge clock) begin
        if (!reset_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
    // storage write; contents need no reset since occupancy guards reads
    always_ff @(posedge clock) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: decoupled fetch stage with credit-limited requests, redirect/flush and fault halt
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN      = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [XLEN-1:0]    instr_pc,
    output logic               fetch_fault
);
    localparam int CW = $clog2(BUF_DEPTH);
    fetch_state_t            r_state;
    fetch_state_t            w_state_next;
    logic [XLEN-1:0]         r_fetch_pc;
    logic [XLEN-1:0]         r_resp_pc;
    logic [CW:0]             r_outstanding;
    logic [CW:0]             w_outstanding_next;
    logic [CW:0]             w_count;
    logic [XLEN+INSTR_W-1:0] w_head;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_issue;
    logic                    w_resp;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_redirect_ok;
    logic                    w_redirect_bad;
    // buffered plus in-flight entries never exceed the buffer, so a push always has room
    assign imem_req_valid     = reset_n && r_state == RUN &&
                                ({1'b0, w_count} + {1'b0, r_outstanding}) < (CW+2)'(BUF_DEPTH);
    assign imem_req_addr      = r_fetch_pc;
    assign w_issue            = imem_req_valid && imem_req_ready;
    assign w_resp             = imem_resp_valid && r_outstanding != '0;
    assign w_outstanding_next = r_outstanding + (CW+1)'(w_issue) - (CW+1)'(w_resp);
    assign w_redirect_ok      = redirect_valid && redirect_pc[1:0] == 2'b00;
    assign w_redirect_bad     = redirect_valid && redirect_pc[1:0] != 2'b00;
    assign w_push             = w_resp && r_state == RUN && !redirect_valid;
    assign instr_valid        = !w_empty && r_state == RUN;
    assign w_pop              = instr_valid && instr_ready;
    assign instr              = instr_valid ? w_head[INSTR_W-1:0] : '0;
    assign instr_pc           = instr_valid ? w_head[XLEN+INSTR_W-1:INSTR_W] : '0;
    assign fetch_fault        = r_state == HALT;
    sync_fifo #(
        .WIDTH(XLEN + INSTR_W),
        .DEPTH(BUF_DEPTH)
    ) u_buf (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_wdata ({r_resp_pc, imem_resp_data}),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
    // next state: redirects dominate; drain ends once no response is still in flight
    always_comb begin
        w_state_next = r_state;
        if (w_redirect_bad) w_state_next = HALT;
        else if (w_redirect_ok) w_state_next = (w_outstanding_next != '0) ? DRAIN : RUN;
        else if (r_state == DRAIN && w_outstanding_next == '0) w_state_next = RUN;
    end
    // state, PC and in-flight tracking; an aligned redirect reloads both PCs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state       <= RUN;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
        end else begin
            r_state       <= w_state_next;
            r_outstanding <= w_outstanding_next;
            if (w_redirect_ok) begin
                r_fetch_pc <= redirect_pc;
                r_resp_pc  <= redirect_pc;
            end else begin
                if (w_issue) r_fetch_pc <= r_fetch_pc + XLEN'(PC_STEP);
                if (w_push) r_resp_pc <= r_resp_pc + XLEN'(PC_STEP);
            end
        end
    end
    a_unsolicited_resp: assert property (@(posedge clock) disable iff (!reset_n)
        imem_resp_valid |-> r_outstanding != '0);
    a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        w_push |-> (!w_full || w_pop));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch streaming, backpressure, redirect, fault and reset
module tb_instr_fetch_unit;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_fault;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat = 1;
    int last_due = 0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] req_log[$];
    logic [31:0] cons_pc[$];
    logic [31:0] cons_data[$];

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .BUF_DEPTH(4)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .fetch_fault     (fetch_fault)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // memory model and decoder monitor, evaluated mid-cycle for the upcoming edge
    initial begin
        int due;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                pend_addr.delete();
                pend_due.delete();
                last_due = 0;
                imem_resp_valid = 1'b0;
                imem_resp_data = '0;
            end else begin
                if (imem_req_valid && imem_req_ready) begin
                    due = (cyc + 1 + lat > last_due + 1) ? cyc + 1 + lat : last_due + 1;
                    last_due = due;
                    pend_addr.push_back(imem_req_addr);
                    pend_due.push_back(due);
                    req_log.push_back(imem_req_addr);
                end
                if (pend_due.size() > 0 && pend_due[0] == cyc + 1) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data = {16'hC0DE, pend_addr[0][15:0]};
                    void'(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end else begin
                    imem_resp_valid = 1'b0;
                    imem_resp_data = '0;
                end
                if (instr_valid && instr_ready && !redirect_valid) begin
                    cons_pc.push_back(instr_pc);
                    cons_data.push_back(instr);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        imem_req_ready = 1'b1;
        tick(2);
        req_log.delete();
        cons_pc.delete();
        cons_data.delete();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%0b exp=0", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'h0) begin failures++; $display("FAIL reset_req_addr got=%h exp=0", imem_req_addr); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid got=%0b exp=0", instr_valid); end
        checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h/%h exp=0/0", instr, instr_pc); end
        checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%0b exp=0", fetch_fault); end
    endtask

    task automatic test_stream();
        do_reset();
        lat = 1;
        instr_ready = 1'b1;
        reset_n = 1'b1;
        tick();
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL stream_early_valid got=%0b exp=0", instr_valid); end
        checks++; if (imem_req_addr !== 32'h4) begin failures++; $display("FAIL stream_second_addr got=%h exp=4", imem_req_addr); end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'hC0DE0000) begin failures++; $display("FAIL stream_first got=%0b/%h/%h exp=1/0/c0de0000", instr_valid, instr_pc, instr); end
        tick(6);
        checks++; if (req_log.size() < 5 || cons_pc.size() < 4) begin failures++; $display("FAIL stream_counts got=%0d/%0d exp>=5/4", req_log.size(), cons_pc.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (req_log[i] !== 32'(4 * i)) begin failures++; $display("FAIL stream_req%0d got=%h exp=%h", i, req_log[i], 32'(4 * i)); end
            end
            for (int i = 0; i < 4; i++) begin
                checks++; if (cons_pc[i] !== 32'(4 * i) || cons_data[i] !== (32'hC0DE0000 | 32'(4 * i))) begin failures++; $display("FAIL stream_cons%0d got=%h/%h exp=%h", i, cons_pc[i], cons_data[i], 32'(4 * i)); end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        lat = 1;
        reset_n = 1'b1;
        tick(20);
        checks++; if (req_log.size() != 4) begin failures++; $display("FAIL bp_req_count got=%0d exp=4", req_log.size()); end
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_req_valid got=%0b exp=0", imem_req_valid); end
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'hC0DE0000) begin failures++; $display("FAIL bp_head got=%0b/%h/%h exp=1/0/c0de0000", instr_valid, instr_pc, instr); end
        instr_ready = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_before_pop got=%0b exp=0", imem_req_valid); end
        tick();
        instr_ready = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin failures++; $display("FAIL bp_after_pop got=%0b/%h exp=1/10", imem_req_valid, imem_req_addr); end
        checks++; if (instr_pc !== 32'h4) begin failures++; $display("FAIL bp_next_head got=%h exp=4", instr_pc); end
    endtask

    task automatic test_redirect_drain();
        do_reset();
        lat = 3;
        instr_ready = 1'b1;
        reset_n = 1'b1;
        tick(2);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL drain_req1 got=%0b exp=0", imem_req_valid); end
        tick();
        checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL drain_req2 got=%0b/%0b exp=0/0", imem_req_valid, instr_valid); end
        tick();
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin failures++; $display("FAIL drain_resume got=%0b/%h exp=1/100", imem_req_valid, imem_req_addr); end
        tick(12);
        checks++; if (cons_pc.size() < 2 || cons_pc[0] !== 32'h100 || cons_data[0] !== 32'hC0DE0100 || cons_pc[1] !== 32'h104) begin failures++; $display("FAIL drain_delivery got_n=%0d first=%h exp=100", cons_pc.size(), cons_pc.size() > 0 ? cons_pc[0] : 32'hx); end
    endtask

    task automatic test_fault();
        int hi = 0;
        int mark;
        do_reset();
        lat = 1;
        instr_ready = 1'b1;
        reset_n = 1'b1;
        tick(4);
        redirect_valid = 1'b1;
        redirect_pc = 32'h102;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (fetch_fault !== 1'b1 || instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin failures++; $display("FAIL fault_enter got=%0b/%0b/%0b exp=1/0/0", fetch_fault, instr_valid, imem_req_valid); end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) hi++;
        end
        checks++; if (hi != 0 || fetch_fault !== 1'b1) begin failures++; $display("FAIL fault_hold active_cycles=%0d fault=%0b exp=0/1", hi, fetch_fault); end
        mark = cons_pc.size();
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (fetch_fault !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin failures++; $display("FAIL fault_clear got=%0b/%0b/%h exp=0/1/200", fetch_fault, imem_req_valid, imem_req_addr); end
        tick(5);
        checks++; if (cons_pc.size() <= mark || cons_pc[mark] !== 32'h200 || cons_data[mark] !== 32'hC0DE0200) begin failures++; $display("FAIL fault_resume got_n=%0d exp first=200", cons_pc.size() - mark); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        lat = 2;
        instr_ready = 1'b1;
        reset_n = 1'b1;
        tick(3);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin failures++; $display("FAIL b2b_pre got=%0b/%h exp=1/0", instr_valid, instr_pc); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin failures++; $display("FAIL b2b_flush got=%0b/%0b exp=0/0", instr_valid, imem_req_valid); end
        tick();
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0b exp=0", imem_req_valid); end
        tick();
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin failures++; $display("FAIL b2b_resume got=%0b/%h exp=1/300", imem_req_valid, imem_req_addr); end
        tick(6);
        checks++; if (cons_pc.size() < 1 || cons_pc[0] !== 32'h300 || cons_data[0] !== 32'hC0DE0300) begin failures++; $display("FAIL b2b_first got_n=%0d first=%h exp=300", cons_pc.size(), cons_pc.size() > 0 ? cons_pc[0] : 32'hx); end
    endtask

    task automatic test_wrap_reset();
        int rmark;
        int cmark;
        do_reset();
        lat = 1;
        instr_ready = 1'b1;
        reset_n = 1'b1;
        tick(3);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFFFFFC;
        tick();
        redirect_valid = 1'b0;
        rmark = req_log.size();
        cmark = cons_pc.size();
        tick(6);
        checks++; if (req_log.size() < rmark + 2 || req_log[rmark] !== 32'hFFFFFFFC || req_log[rmark + 1] !== 32'h0) begin failures++; $display("FAIL wrap_req got_n=%0d exp fffffffc,0", req_log.size() - rmark); end
        checks++; if (cons_pc.size() < cmark + 2 || cons_pc[cmark] !== 32'hFFFFFFFC || cons_data[cmark] !== 32'hC0DEFFFC || cons_pc[cmark + 1] !== 32'h0) begin failures++; $display("FAIL wrap_cons got_n=%0d exp fffffffc,0", cons_pc.size() - cmark); end
        lat = 4;
        tick(2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h400;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL wrap_drain got=%0b/%0b exp=0/0", imem_req_valid, instr_valid); end
        reset_n = 1'b0;
        tick();
        checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 || fetch_fault !== 1'b0 || imem_req_addr !== 32'h0) begin failures++; $display("FAIL midreset_outputs got=%0b/%0b/%h/%h/%0b/%h exp=all0", imem_req_valid, instr_valid, instr, instr_pc, fetch_fault, imem_req_addr); end
        lat = 1;
        reset_n = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin failures++; $display("FAIL midreset_restart got=%0b/%h exp=1/0", imem_req_valid, imem_req_addr); end
        cmark = cons_pc.size();
        tick(4);
        checks++; if (cons_pc.size() <= cmark || cons_pc[cmark] !== 32'h0 || cons_data[cmark] !== 32'hC0DE0000) begin failures++; $display("FAIL midreset_deliver got_n=%0d exp first=0", cons_pc.size() - cmark); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drain();
        test_fault();
        test_back_to_back();
        test_wrap_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
